// File: rtl/booth_controller.sv
// ---------------------------------------------------------------------------
// booth_controller
//
// Control FSM for a sequential radix-2 Booth multiplier. An operand pair is
// accepted through a valid/ready handshake, loaded into the datapath, and then
// WIDTH evaluate/shift iterations are sequenced. Each EVAL cycle decodes the
// Booth bit pair {Q0, Q-1} into add/subtract/no-op. Each SHIFT cycle strobes
// the arithmetic right shift and steps the external iteration counter. The
// finished product is offered through a second valid/ready handshake.
//
// Parameters:
//   WIDTH      operand width and number of Booth iterations (2..2**CNT_WIDTH)
//   CNT_WIDTH  width of the external iteration counter value on count
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   reset          synchronous active-low reset (0 = reset)
//   src_valid      operand pair available upstream
//   src_ready      controller can accept operands (IDLE, reset released)
//   dst_valid      product complete in datapath (DONE)
//   dst_ready      downstream consumes product
//   count          completed-iteration count from the external counter
//   booth_bits     {Q0, Q-1} from the multiplier register
//   start          clears the external iteration counter (LOAD)
//   load_operands  loads M, Q, A=0, Q-1=0 (LOAD)
//   alu_op         00 none, 01 A+=M, 10 A-=M (EVAL only)
//   shift_en       arithmetic right shift of {A,Q,Q-1} (SHIFT)
//   en_pp          partial-product step, increments the counter (SHIFT)
//   busy           any state other than IDLE
// ---------------------------------------------------------------------------
module booth_controller #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 src_valid,
   output logic                 src_ready,
   output logic                 dst_valid,
   input  logic                 dst_ready,
   input  logic [CNT_WIDTH-1:0] count,
   input  logic [1:0]           booth_bits,
   output logic                 start,
   output logic                 load_operands,
   output logic [1:0]           alu_op,
   output logic                 shift_en,
   output logic                 en_pp,
   output logic                 busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      EVAL  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Count value seen in the SHIFT of the final iteration.
   localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WIDTH - 1);

   state_t state_r;
   state_t next_state_s;

   // State register; reset forces IDLE from any state, aborting an operation.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic and output decode.
   always_comb begin
      next_state_s  = state_r;
      src_ready     = 1'b0;
      dst_valid     = 1'b0;
      start         = 1'b0;
      load_operands = 1'b0;
      alu_op        = 2'b00;
      shift_en      = 1'b0;
      en_pp         = 1'b0;
      busy          = 1'b1;

      case (state_r)
         IDLE: begin
            busy = 1'b0;
            // Gated by reset so upstream never sees a handshake while held in reset.
            src_ready = reset;
            if (src_valid && src_ready) begin
               next_state_s = LOAD;
            end else begin
               next_state_s = IDLE;
            end
         end

         LOAD: begin
            load_operands = 1'b1;
            start         = 1'b1;
            next_state_s  = EVAL;
         end

         EVAL: begin
            case (booth_bits)
               2'b01:   alu_op = 2'b01;
               2'b10:   alu_op = 2'b10;
               default: alu_op = 2'b00;
            endcase
            next_state_s = SHIFT;
         end

         SHIFT: begin
            shift_en = 1'b1;
            en_pp    = 1'b1;
            // >= rather than == so a counter overrun still terminates the operation.
            if (count >= LAST_ITER) begin
               next_state_s = DONE;
            end else begin
               next_state_s = EVAL;
            end
         end

         DONE: begin
            dst_valid = 1'b1;
            if (dst_ready) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = DONE;
            end
         end

         default: begin
            busy         = 1'b0;
            next_state_s = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_booth_controller.sv
// ---------------------------------------------------------------------------
// tb_booth_controller
//
// Directed testbench for booth_controller (WIDTH=16, CNT_WIDTH=5). Models the
// external iteration counter, walks the controller cycle by cycle and checks
// every output against hand-derived expectations: reset behaviour, a single
// operation with Booth decode patterns, output backpressure, mid-operation
// reset, and back-to-back operation with src_valid held high.
// ---------------------------------------------------------------------------
module tb_booth_controller;

   localparam int WIDTH     = 16;
   localparam int CNT_WIDTH = 5;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 src_valid;
   logic                 src_ready;
   logic                 dst_valid;
   logic                 dst_ready;
   logic [CNT_WIDTH-1:0] count = '0;
   logic [1:0]           booth_bits;
   logic                 start;
   logic                 load_operands;
   logic [1:0]           alu_op;
   logic                 shift_en;
   logic                 en_pp;
   logic                 busy;

   int n_checks  = 0;
   int n_errors  = 0;
   int cyc       = 0;
   int prev_acc  = -1;
   bit prev_held = 1'b0;

   // Booth pairs driven in successive EVALs and the alu_op each must produce.
   logic [1:0] bb_pat  [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
   logic [1:0] exp_alu [4] = '{2'b01, 2'b10, 2'b00, 2'b00};

   booth_controller #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .src_valid     (src_valid),
      .src_ready     (src_ready),
      .dst_valid     (dst_valid),
      .dst_ready     (dst_ready),
      .count         (count),
      .booth_bits    (booth_bits),
      .start         (start),
      .load_operands (load_operands),
      .alu_op        (alu_op),
      .shift_en      (shift_en),
      .en_pp         (en_pp),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency and spacing measurements.
   always @(posedge clk) cyc <= cyc + 1;

   // External iteration counter: cleared by start, stepped by en_pp.
   always @(posedge clk) begin
      if (start) begin
         count <= '0;
      end else if (en_pp) begin
         count <= count + 1'b1;
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic e_sr, input logic e_ld,
                           input logic e_st, input logic [1:0] e_alu, input logic e_sh,
                           input logic e_en, input logic e_dv, input logic e_bz);
      chk({tag, ".src_ready"},     32'(src_ready),     32'(e_sr));
      chk({tag, ".load_operands"}, 32'(load_operands), 32'(e_ld));
      chk({tag, ".start"},         32'(start),         32'(e_st));
      chk({tag, ".alu_op"},        32'(alu_op),        32'(e_alu));
      chk({tag, ".shift_en"},      32'(shift_en),      32'(e_sh));
      chk({tag, ".en_pp"},         32'(en_pp),         32'(e_en));
      chk({tag, ".dst_valid"},     32'(dst_valid),     32'(e_dv));
      chk({tag, ".busy"},          32'(busy),          32'(e_bz));
   endtask

   // One operation starting in an IDLE cycle. abort_iter >= 0 asserts reset in
   // that iteration's SHIFT; bp is the number of extra DONE cycles with
   // dst_ready low; hold_valid keeps src_valid high for the whole operation.
   task automatic do_op(input int abort_iter, input int bp, input bit hold_valid);
      int t_acc;
      int n_en;
      int n_sh;
      n_en = 0;
      n_sh = 0;
      src_valid = 1'b1;
      dst_ready = (bp == 0);
      #1;
      chk("accept.src_ready", 32'(src_ready), 32'd1);
      t_acc = cyc;
      // Accept at T, DONE at T+2W+2, IDLE (next accept) at T+2W+3.
      if (hold_valid && prev_held) begin
         chk("accept_spacing", 32'(t_acc - prev_acc), 32'(2 * WIDTH + 3));
      end
      prev_acc = t_acc;

      tick();
      if (!hold_valid) src_valid = 1'b0;
      #1;
      chk_outs("load", 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < WIDTH; i++) begin
         tick();
         booth_bits = bb_pat[i % 4];
         #1;
         chk_outs("eval", 1'b0, 1'b0, 1'b0, exp_alu[i % 4], 1'b0, 1'b0, 1'b0, 1'b1);
         tick();
         #1;
         chk_outs("shift", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
         chk("shift.count", 32'(count), 32'(i));
         if (en_pp) n_en++;
         if (shift_en) n_sh++;
         if (i == abort_iter) begin
            reset = 1'b0;
            tick();
            chk_outs("abort_in_reset", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            reset     = 1'b1;
            src_valid = 1'b0;
            #1;
            chk("abort_release.src_ready", 32'(src_ready), 32'd1);
            repeat (3) begin
               tick();
               chk_outs("abort_idle", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            prev_held = 1'b0;
            return;
         end
      end

      tick();
      #1;
      chk_outs("done", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("done_latency", 32'(cyc - t_acc), 32'(2 * WIDTH + 2));
      chk("en_pp_pulses", 32'(n_en), 32'(WIDTH));
      chk("shift_pulses", 32'(n_sh), 32'(WIDTH));

      for (int k = 0; k < bp; k++) begin
         tick();
         chk_outs("done_hold", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      end
      dst_ready = 1'b1;
      #1;
      tick();
      chk_outs("idle_after", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      prev_held = hold_valid;
   endtask

   initial begin
      reset      = 1'b0;
      src_valid  = 1'b1;
      dst_ready  = 1'b1;
      booth_bits = 2'b01;

      // Held in reset with traffic offered: nothing may happen.
      repeat (3) begin
         tick();
         chk_outs("reset_hold", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      reset     = 1'b1;
      src_valid = 1'b0;
      #1;
      chk("reset_release.src_ready", 32'(src_ready), 32'd1);
      tick();
      chk_outs("idle", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Single operation with the Booth decode patterns.
      do_op(-1, 0, 1'b0);
      // Output backpressure for 10 DONE cycles.
      do_op(-1, 10, 1'b0);
      // Reset during the SHIFT where count is 7.
      do_op(7, 0, 1'b0);
      // Normal operation after the abort.
      do_op(-1, 0, 1'b0);
      // Back-to-back with src_valid held high.
      do_op(-1, 0, 1'b1);
      do_op(-1, 0, 1'b1);
      do_op(-1, 0, 1'b1);

      src_valid = 1'b0;
      tick();
      chk_outs("final_idle", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
